weighted_round_robin_arbiter: RTL and testbench

WEIGHTED_ROUND_ROBIN_ARBITER -- requirements
Module: weighted_round_robin_arbiter

---
 rtl/wrr_pkg.sv | 13 +
 rtl/wrr_pick.sv | 41 ++++
 rtl/weighted_round_robin_arbiter.sv | 159 +++++++++++++++
 tb/tb_weighted_round_robin_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wrr_pkg.sv
// rtl/wrr_pkg.sv - shared state encoding and defaults for the weighted round-robin arbiter
package wrr_pkg;

  // Default width of one requester weight / credit counter.
  localparam int WRR_WEIGHT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no grant presented
    ST_GRANT = 2'd1,  // grant presented, waiting for grant_ready_i
    ST_LOCK  = 2'd2   // grant held by lock_i (only reachable with WRR_LOCK_EN)
  } wrr_state_e;

endpackage

// File: rtl/wrr_pick.sv
// rtl/wrr_pick.sv - rotating priority encoder: first set bit at or above ptr, modulo NUM_REQ
//
// Ports:
//   eligible - candidate mask, bit i = requester i may win
//   ptr      - index where the upward scan starts
//   onehot   - one-hot winner (zero when none found)
//   idx      - binary winner index (zero when none found)
//   found    - at least one eligible bit was set
module wrr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    onehot  = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!found && eligible[pos_idx]) begin
        found           = 1'b1;
        idx             = pos_idx;
        onehot[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weighted_round_robin_arbiter.sv
// rtl/weighted_round_robin_arbiter.sv - credit-based weighted round-robin arbiter with valid/ready grant
//
// Optional feature: define WRR_LOCK_EN to add lock_i and the LOCK state.
//
// Ports:
//   clk_i, rst_n_i  - clock, asynchronous active-low reset
//   req_i           - request mask, one bit per requester
//   req_en_i        - allows a new grant to be issued
//   weight_i        - packed weights, requester i at [i*WEIGHT_W +: WEIGHT_W]
//   grant_ready_i   - consumer accepts the presented grant
//   lock_i          - (WRR_LOCK_EN) keep the current winner across the handshake
//   grant_o         - one-hot grant, zero when not valid
//   grant_valid_o   - grant_o / grant_id_o are valid
//   grant_id_o      - binary index of the granted requester
module weighted_round_robin_arbiter
  import wrr_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = WRR_WEIGHT_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic                        req_en_i,
  input  logic [NUM_REQ*WEIGHT_W-1:0] weight_i,
  input  logic                        grant_ready_i,
`ifdef WRR_LOCK_EN
  input  logic                        lock_i,
`endif
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        grant_valid_o,
  output logic [IDX_W-1:0]            grant_id_o
);

  wrr_state_e           state_q, state_n;
  logic [WEIGHT_W-1:0]  credit_q    [NUM_REQ];
  logic [WEIGHT_W-1:0]  credit_post [NUM_REQ];
  logic [WEIGHT_W-1:0]  credit_n    [NUM_REQ];
  logic [IDX_W-1:0]     ptr_q, ptr_post, ptr_n;
  logic [WEIGHT_W-1:0]  dec_credit;
  logic [NUM_REQ-1:0]   eligible;
  logic                 hs, lock_hs, arb_go, rearb;
  logic [NUM_REQ-1:0]   grant_n;
  logic [IDX_W-1:0]     id_n;
  logic                 valid_n;

  logic [NUM_REQ-1:0]   pick_onehot, rl_onehot;
  logic [IDX_W-1:0]     pick_idx, rl_idx;
  logic                 pick_found, rl_found;

  // Apply the handshake first: everything downstream arbitrates on the
  // post-handshake credits and pointer so back-to-back grants have no bubble.
  always_comb begin
    hs = grant_valid_o & grant_ready_i;
`ifdef WRR_LOCK_EN
    lock_hs = hs & lock_i;
`else
    lock_hs = 1'b0;
`endif
    credit_post = credit_q;
    ptr_post    = ptr_q;
    dec_credit  = '0;
    if (hs) begin
      dec_credit = (credit_q[grant_id_o] == '0) ? '0 : credit_q[grant_id_o] - 1'b1;
      credit_post[grant_id_o] = dec_credit;
      // A winner with credit left keeps the pointer and so wins again next.
      if (dec_credit != '0)                        ptr_post = grant_id_o;
      else if (grant_id_o == IDX_W'(NUM_REQ - 1))  ptr_post = '0;
      else                                         ptr_post = grant_id_o + 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_i[i] & (credit_post[i] != '0);
    end
    arb_go = req_en_i & (|req_i);
  end

  // Normal pick among requesters with credit left.
  wrr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .eligible (eligible),
    .ptr      (ptr_post),
    .onehot   (pick_onehot),
    .idx      (pick_idx),
    .found    (pick_found)
  );

  // Pick used when credits are exhausted: after a reload every credit is >= 1,
  // so the eligible set is just the request mask.
  wrr_pick #(.NUM_REQ(NUM_REQ)) u_pick_reload (
    .eligible (req_i),
    .ptr      (ptr_post),
    .onehot   (rl_onehot),
    .idx      (rl_idx),
    .found    (rl_found)
  );

  always_comb begin
    state_n  = state_q;
    grant_n  = grant_o;
    id_n     = grant_id_o;
    valid_n  = grant_valid_o;
    credit_n = credit_post;
    ptr_n    = ptr_post;
    rearb    = 1'b0;

    case (state_q)
      ST_IDLE: rearb = 1'b1;
      ST_GRANT,
      ST_LOCK: begin
        if (lock_hs)  state_n = ST_LOCK;
        else if (hs)  rearb   = 1'b1;
      end
      default: rearb = 1'b1;
    endcase

    if (rearb) begin
      if (arb_go && (pick_found || rl_found)) begin
        state_n = ST_GRANT;
        valid_n = 1'b1;
        if (pick_found) begin
          grant_n = pick_onehot;
          id_n    = pick_idx;
        end else begin
          grant_n = rl_onehot;
          id_n    = rl_idx;
          // Weights are only sampled here; a zero weight still earns one grant.
          for (int i = 0; i < NUM_REQ; i++) begin
            credit_n[i] = (weight_i[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                          WEIGHT_W'(1) : weight_i[i*WEIGHT_W +: WEIGHT_W];
          end
        end
      end else begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
        grant_n = '0;
        id_n    = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      grant_o       <= '0;
      grant_valid_o <= 1'b0;
      grant_id_o    <= '0;
      ptr_q         <= '0;
      for (int i = 0; i < NUM_REQ; i++) credit_q[i] <= '0;
    end else begin
      state_q       <= state_n;
      grant_o       <= grant_n;
      grant_valid_o <= valid_n;
      grant_id_o    <= id_n;
      ptr_q         <= ptr_n;
      credit_q      <= credit_n;
    end
  end

endmodule

// File: tb/tb_weighted_round_robin_arbiter.sv
// tb/tb_weighted_round_robin_arbiter.sv - self-checking bench for weighted_round_robin_arbiter
module tb_weighted_round_robin_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic        en = 1'b0;
  logic [15:0] weight = {4'd3, 4'd1, 4'd2, 4'd1};
  logic        ready = 1'b0;
`ifdef WRR_LOCK_EN
  logic        lock = 1'b0;
`endif
  logic [3:0]  grant;
  logic        gvalid;
  logic [1:0]  gid;

  int checks = 0;
  int failures = 0;

  // Reference model: credits, pointer and current winner as plain integers.
  int cred [4];
  int ptr;
  bit mvalid;
  int mid;

  weighted_round_robin_arbiter #(.NUM_REQ(4), .WEIGHT_W(4)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .req_i         (req),
    .req_en_i      (en),
    .weight_i      (weight),
    .grant_ready_i (ready),
`ifdef WRR_LOCK_EN
    .lock_i        (lock),
`endif
    .grant_o       (grant),
    .grant_valid_o (gvalid),
    .grant_id_o    (gid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int scan(input logic [3:0] mask, input int p);
    for (int k = 0; k < 4; k++) begin
      if (mask[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) cred[i] = 0;
    ptr = 0;
    mvalid = 0;
    mid = 0;
  endtask

  // Predicts the state after the next rising edge from the current inputs.
  task automatic model_step();
    bit hs, locked;
    logic [3:0] elig;
    int w;
    hs = mvalid && ready;
    locked = 0;
`ifdef WRR_LOCK_EN
    locked = hs && lock;
`endif
    if (hs) begin
      if (cred[mid] > 0) cred[mid] = cred[mid] - 1;
      ptr = (cred[mid] > 0) ? mid : (mid + 1) % 4;
    end
    if (!locked && (!mvalid || hs)) begin
      if (en && req != 4'b0) begin
        for (int i = 0; i < 4; i++) elig[i] = req[i] && (cred[i] > 0);
        w = scan(elig, ptr);
        if (w < 0) begin
          for (int i = 0; i < 4; i++) begin
            cred[i] = int'(weight[i*4 +: 4]);
            if (cred[i] == 0) cred[i] = 1;
          end
          w = scan(req, ptr);
        end
        mvalid = 1;
        mid = w;
      end else begin
        mvalid = 0;
      end
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_valid"}, 32'(gvalid), 32'(mvalid));
    check({tag, "_grant"}, 32'(grant), mvalid ? (32'd1 << mid) : 32'd0);
    check({tag, "_id"}, 32'(gid), mvalid ? 32'(mid) : 32'd0);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_out({tag, "_async"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_out({tag, "_hold"});
  endtask

  logic [3:0] seq30 [8] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100,
                            4'b1000, 4'b1000, 4'b1000, 4'b0001};
  logic [3:0] seq31 [6] = '{4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b1000};

  initial begin
    #2;
    do_reset("reset");

    // Full request, always ready: weighted rotation.
    req = 4'b1111; en = 1'b1; ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle("r030");
      check("r030_seq", 32'(grant), 32'(seq30[k]));
    end

    // Only requesters 0 and 3.
    do_reset("r031_rst");
    req = 4'b1001;
    for (int k = 0; k < 6; k++) begin
      cycle("r031");
      check("r031_seq", 32'(grant), 32'(seq31[k]));
    end

    // Backpressure holds the grant even when req changes.
    do_reset("r032_rst");
    req = 4'b1111;
    cycle("r032_a");
    cycle("r032_b");
    ready = 1'b0; req = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      cycle("r032_hold");
      check("r032_grant", 32'(grant), 32'h2);
      check("r032_id", 32'(gid), 32'h1);
    end
    ready = 1'b1;
    cycle("r032_release");

    // Enable low blocks grants; first grant one edge after enable rises.
    do_reset("r033_rst");
    en = 1'b0; req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      cycle("r033_off");
      check("r033_novalid", 32'(gvalid), 32'h0);
    end
    en = 1'b1;
    cycle("r033_on");
    check("r033_first", 32'(grant), 32'h1);

    // Reset asserted mid-grant drops the grant immediately.
    cycle("r034_run");
    check("r034_pre", 32'(gvalid), 32'h1);
    do_reset("r034_rst");
    req = 4'b1111; en = 1'b1;
    cycle("r034_after");
    check("r034_first", 32'(grant), 32'h1);

`ifdef WRR_LOCK_EN
    // Lock keeps requester 0 for five beats despite weight 1.
    do_reset("r035_rst");
    weight = {4'd3, 4'd1, 4'd2, 4'd1};
    req = 4'b1111; en = 1'b1; ready = 1'b1; lock = 1'b0;
    cycle("r035_first");
    check("r035_beat", 32'(grant), 32'h1);
    lock = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle("r035_lock");
      check("r035_beat", 32'(grant), 32'h1);
    end
    lock = 1'b0;
    cycle("r035_unlock");
    check("r035_next", 32'(grant), 32'h2);
`endif

    // Randomized traffic, including zero weights and weight changes.
    do_reset("rand_rst");
    for (int k = 0; k < 400; k++) begin
      req   = 4'($urandom);
      en    = ($urandom_range(0, 3) != 0);
      ready = 1'($urandom);
      if ($urandom_range(0, 15) == 0) weight = 16'($urandom);
`ifdef WRR_LOCK_EN
      lock  = ($urandom_range(0, 3) == 0);
`endif
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
